cond_decode_stage: RTL

Registered, flow-controlled successor to the combinational conditional decoder. It sits between fetch and execute and holds one instruction. It resolves conditional branches (Bcond) and conditional jumps (Jcond) against the processor flags, and passes either the instruction or a NOP to execute. Unlike the combinational decoder, it stalls conditional instructions while the execute stage still owes a flag update, supports pipeline flush, and counts squashed instructions.

---
 rtl/cond_decode_pkg.sv | 27 ++
 rtl/cond_decode_stage_if.sv | 28 ++
 rtl/cond_decode_stage_cond_eval.sv | 44 ++++
 rtl/cond_decode_stage.sv | 122 ++++++++++++
 4 files changed

// File: rtl/cond_decode_pkg.sv
// Shared opcode constants, condition codes and FSM states for the
// conditional decode stage.
package cond_decode_pkg;

  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_JGRP   = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] OP_NULL   = 4'b0000;
  localparam logic [3:0] EXT_NULL  = 4'b0000;

  typedef enum logic [3:0] {
    COND_ZS, COND_ZC, COND_CS, COND_CC, COND_LS, COND_LC, COND_NS, COND_NC,
    COND_FS, COND_FC, COND_GT, COND_LE, COND_ABOVE, COND_BELOW,
    COND_ALWAYS, COND_NEVER
  } cond_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT_FLAGS,
    ST_FULL
  } state_e;

  function automatic logic is_cond_op(input logic [3:0] op, input logic [3:0] ext);
    return (op == OP_BCOND) || ((op == OP_JGRP) && (ext == EXT_JCOND));
  endfunction

endpackage

// File: rtl/cond_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the conditional decode stage.
interface cond_decode_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [4:0]         flags;
  logic               flags_stale;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic               out_is_cond;
  logic               out_taken;
  logic [CNT_W-1:0]   squash_count;

  modport slave (
    input  in_valid, in_instr, flags, flags_stale, flush, out_ready,
    output in_ready, out_valid, out_instr, out_is_cond, out_taken, squash_count
  );

  modport master (
    output in_valid, in_instr, flags, flags_stale, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_is_cond, out_taken, squash_count
  );
endinterface

// File: rtl/cond_decode_stage_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against the flag vector.
module cond_eval
  import cond_decode_pkg::*;
#(
  parameter int Z_IDX = 3,
  parameter int C_IDX = 0,
  parameter int L_IDX = 1,
  parameter int N_IDX = 4,
  parameter int F_IDX = 2
) (
  input  cond_e      cond,
  input  logic [4:0] flags,
  output logic       taken
);
  logic z, c, l, n, f;

  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign l = flags[L_IDX];
  assign n = flags[N_IDX];
  assign f = flags[F_IDX];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_ZS:     taken = z;
      COND_ZC:     taken = !z;
      COND_CS:     taken = c;
      COND_CC:     taken = !c;
      COND_LS:     taken = l;
      COND_LC:     taken = !l;
      COND_NS:     taken = n;
      COND_NC:     taken = !n;
      COND_FS:     taken = f;
      COND_FC:     taken = !f;
      COND_GT:     taken = !z && !l;
      COND_LE:     taken = z || l;
      COND_ABOVE:  taken = !n && !c;
      COND_BELOW:  taken = n || c;
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_decode_stage.sv
// One-entry decode stage: resolves Bcond/Jcond against flags, stalls on stale
// flags, supports flush and counts squashed conditionals.
module cond_decode_stage
  import cond_decode_pkg::*;
#(
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0020,
  parameter int                 Z_IDX     = 3,
  parameter int                 C_IDX     = 0,
  parameter int                 L_IDX     = 1,
  parameter int                 N_IDX     = 4,
  parameter int                 F_IDX     = 2,
  parameter int                 CNT_W     = 16
) (
  input logic         clock,
  input logic         reset,
  cond_decode_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e             state, state_nxt;
  logic [INSTR_W-1:0] held;
  logic               accept, in_cond, wait_load, eval_en;
  logic [INSTR_W-1:0] src;
  logic [3:0]         src_op, src_ext;
  logic               src_cond, taken;
  logic [INSTR_W-1:0] dec_instr;
  logic               dec_taken, squash;

  assign bus.in_ready = !bus.flush &&
                        ((state == ST_EMPTY) || ((state == ST_FULL) && bus.out_ready));
  assign accept  = bus.in_valid && bus.in_ready;
  assign in_cond = is_cond_op(bus.in_instr[INSTR_W-1 -: 4], bus.in_instr[7:4]);

  // WAIT_FLAGS re-evaluates the parked instruction; otherwise decode the incoming one.
  assign src      = (state == ST_WAIT_FLAGS) ? held : bus.in_instr;
  assign src_op   = src[INSTR_W-1 -: 4];
  assign src_ext  = src[7:4];
  assign src_cond = is_cond_op(src_op, src_ext);

  cond_eval #(
    .Z_IDX(Z_IDX), .C_IDX(C_IDX), .L_IDX(L_IDX), .N_IDX(N_IDX), .F_IDX(F_IDX)
  ) u_eval (
    .cond  (cond_e'(src[11:8])),
    .flags (bus.flags),
    .taken (taken)
  );

  always_comb begin
    state_nxt = state;
    eval_en   = 1'b0;
    wait_load = 1'b0;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY, ST_FULL: begin
          if ((state == ST_FULL) && bus.out_ready) state_nxt = ST_EMPTY;
          if (accept) begin
            if (in_cond && bus.flags_stale) begin
              state_nxt = ST_WAIT_FLAGS;
              wait_load = 1'b1;
            end else begin
              state_nxt = ST_FULL;
              eval_en   = 1'b1;
            end
          end
        end
        ST_WAIT_FLAGS: begin
          if (!bus.flags_stale) begin
            state_nxt = ST_FULL;
            eval_en   = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    dec_instr = src;
    dec_taken = 1'b0;
    squash    = 1'b0;
    if (src_cond) begin
      if (taken) begin
        dec_taken = 1'b1;
        if (src_op == OP_JGRP) dec_instr[11:8] = 4'h0;
      end else begin
        dec_instr = NOP_INSTR;
        squash    = 1'b1;
      end
    end else if ((src_op == OP_NULL) && (src_ext == EXT_NULL)) begin
      dec_instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held             <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_instr    <= NOP_INSTR;
      bus.out_is_cond  <= 1'b0;
      bus.out_taken    <= 1'b0;
      bus.squash_count <= '0;
    end else begin
      bus.out_valid <= (state_nxt == ST_FULL);
      if (wait_load) held <= bus.in_instr;
      if (eval_en) begin
        bus.out_instr   <= dec_instr;
        bus.out_is_cond <= src_cond;
        bus.out_taken   <= dec_taken;
        if (squash && (bus.squash_count != '1))
          bus.squash_count <= bus.squash_count + CNT_ONE;
      end
    end
  end
endmodule
